// File: rtl/test_block_dual_port_ram_top.sv
// Simple dual-port RAM: one write port, one registered read port, READ_FIRST on collision.
// Contents start at zero and survive reset; only the read register is cleared by rst_n.
module test_block_dual_port_ram_top #(
    parameter  int ENTRY_NUM      = 4,
    parameter  int ENTRY_BIT_SIZE = 4,
    localparam int INDEX_BIT_SIZE = $clog2(ENTRY_NUM)
) (
    input  logic                      clk_p,
    input  logic                      clk_n,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [INDEX_BIT_SIZE-1:0] wa,
    input  logic [ENTRY_BIT_SIZE-1:0] wv,
    input  logic [INDEX_BIT_SIZE-1:0] ra,
    output logic [ENTRY_BIT_SIZE-1:0] rv
);

    // The differential clock is consumed on its positive leg only; clk_n is
    // deliberately left unconnected to any logic.
    logic unused_clk_n;
    assign unused_clk_n = clk_n;

    logic [ENTRY_BIT_SIZE-1:0] mem_q [ENTRY_NUM] = '{default: '0};
    logic [ENTRY_BIT_SIZE-1:0] rv_d;
    logic [ENTRY_BIT_SIZE-1:0] rv_q;
    logic                      wr_en;

    // Storage has no reset so it maps onto block RAM; writes are simply
    // gated off while reset is held.
    assign wr_en = we & rst_n;

    always_ff @(posedge clk_p) begin
        if (wr_en) begin
            mem_q[wa] <= wv;
        end
    end

    // The read samples the array before this edge's write lands, which gives
    // READ_FIRST behaviour on a same-address collision.
    assign rv_d = mem_q[ra];

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            rv_q <= '0;
        end else begin
            rv_q <= rv_d;
        end
    end

    assign rv = rv_q;

endmodule

// File: tb/tb_test_block_dual_port_ram_top.sv
// Bench for the dual-port RAM: directed sequence followed by randomized traffic
// with asynchronous reset pulses, checked against an array-based reference model.
module tb_test_block_dual_port_ram_top;

    localparam int N = 4;
    localparam int W = 4;
    localparam int A = $clog2(N);

    logic         clk_p = 1'b0;
    logic         clk_n;
    logic         rst_n;
    logic         we;
    logic [A-1:0] wa;
    logic [W-1:0] wv;
    logic [A-1:0] ra;
    logic [W-1:0] rv;

    logic [W-1:0] mem_m [N];
    logic [W-1:0] exp_rv;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_p = ~clk_p;
    assign clk_n = ~clk_p;

    test_block_dual_port_ram_top #(
        .ENTRY_NUM      (N),
        .ENTRY_BIT_SIZE (W)
    ) dut (
        .clk_p (clk_p),
        .clk_n (clk_n),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wv    (wv),
        .ra    (ra),
        .rv    (rv)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one set of inputs across one rising edge, advance the model, check rv.
    task automatic step(input logic w, input logic [A-1:0] a, input logic [W-1:0] d,
                        input logic [A-1:0] r);
        we = w; wa = a; wv = d; ra = r;
        @(posedge clk_p);
        if (rst_n) begin
            exp_rv = mem_m[r];
            if (w) mem_m[a] = d;
        end else begin
            exp_rv = '0;
        end
        #1 chk("rv", rv, exp_rv);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem_m[i] = '0;
        exp_rv = '0;
        rst_n = 1'b0; we = 1'b0; wa = '0; wv = '0; ra = '0;
        #12;
        chk("reset_rv", rv, 4'h0);
        rst_n = 1'b1;

        step(1'b1, 2'd1, 4'h3, 2'd0);
        chk("init_zero_mem0", rv, 4'h0);
        step(1'b1, 2'd2, 4'h6, 2'd1);
        chk("wr_then_rd_mem1", rv, 4'h3);
        step(1'b0, 2'd2, 4'h9, 2'd1);
        chk("we0_hold", rv, 4'h3);
        step(1'b0, 2'd0, 4'h0, 2'd2);
        chk("we0_no_write", rv, 4'h6);
        step(1'b1, 2'd1, 4'hC, 2'd2);
        chk("wr_rd_diff_addr", rv, 4'h6);
        step(1'b0, 2'd0, 4'h0, 2'd1);
        chk("mem1_updated", rv, 4'hC);
        step(1'b1, 2'd1, 4'hF, 2'd1);
        chk("collision_read_first", rv, 4'hC);
        step(1'b0, 2'd0, 4'h0, 2'd1);
        chk("collision_new_visible", rv, 4'hF);

        // asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1 chk("async_reset_rv", rv, 4'h0);
        exp_rv = '0;
        step(1'b1, 2'd3, 4'h5, 2'd0);
        chk("reset_hold_rv", rv, 4'h0);
        #2 rst_n = 1'b1;
        step(1'b0, 2'd0, 4'h0, 2'd1);
        chk("retained_after_reset", rv, 4'hF);
        step(1'b0, 2'd0, 4'h0, 2'd3);
        chk("write_suppressed_in_reset", rv, 4'h0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 24) == 0) begin
                #1 rst_n = 1'b0;
                #1 chk("rand_async_reset", rv, 4'h0);
                exp_rv = '0;
                if ($urandom_range(0, 1) == 0) begin
                    step(1'($urandom), A'($urandom), W'($urandom), A'($urandom));
                    #2;
                end else begin
                    #1;
                end
                rst_n = 1'b1;
            end
            step(1'($urandom), A'($urandom), W'($urandom), A'($urandom));
        end

        // final sweep of every entry
        for (int i = 0; i < N; i++) step(1'b0, '0, '0, A'(i));
        step(1'b0, '0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/test_block_dual_port_ram_top.md
TEST_BLOCK_DUAL_PORT_RAM_TOP -- requirements
Module: test_block_dual_port_ram_top

Interface
REQ-001 Parameter ENTRY_NUM, default 4, number of RAM entries; SHALL be a power of two, >= 2.
REQ-002 Parameter ENTRY_BIT_SIZE, default 4, width of each entry in bits.
REQ-003 Derived constant INDEX_BIT_SIZE = log2(ENTRY_NUM); SHALL set the width of wa and ra.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk_p  input  1  positive leg of the single system clock; all sequential logic SHALL act on its rising edge.
REQ-006 clk_n  input  1  negative leg of the same clock (always ~clk_p); SHALL NOT be used as an independent clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 we  input  1  write enable for the write port.
REQ-009 wa  input  INDEX_BIT_SIZE  write address.
REQ-010 wv  input  ENTRY_BIT_SIZE  write data.
REQ-011 ra  input  INDEX_BIT_SIZE  read address.
REQ-012 rv  output  ENTRY_BIT_SIZE  registered read data.

Function
REQ-013 Storage SHALL be ENTRY_NUM x ENTRY_BIT_SIZE, one dedicated write port and one dedicated read port, inferable as a simple dual-port block RAM.
REQ-014 Write: on a rising clk_p edge with rst_n high and we=1, mem[wa] SHALL be updated to wv; with we=0 no entry changes.
REQ-015 Read: no read enable; on every rising clk_p edge with rst_n high, rv SHALL be loaded with mem[ra] as it was before that edge (latency exactly 1 cycle).
REQ-016 Between edges rv SHALL hold its value; no combinational path from any input to rv.
REQ-017 Read/write collision (we=1, wa==ra, same edge): READ_FIRST; rv SHALL receive the old content; the new value SHALL be visible to a read issued on the next edge.
REQ-018 Writes to one address SHALL never disturb other addresses; simultaneous write and read to different addresses SHALL both complete in the same cycle.
REQ-019 Addresses cover the full index range; no out-of-range handling needed (ENTRY_NUM is a power of two).
REQ-020 Memory contents SHALL initialise to all zeros at configuration/time zero.

Reset
REQ-021 rst_n low SHALL asynchronously clear rv to 0 and hold it at 0 while low.
REQ-022 Memory contents SHALL NOT be cleared by reset; writes SHALL be suppressed while rst_n is low.
REQ-023 After rst_n deasserts, the first rising edge SHALL perform normal read/write operation.
REQ-024 Reset asserted mid-operation SHALL abort only the rv update; entries written on earlier edges SHALL be retained.

Verification
REQ-025 After reset, write mem[1]=0x3; next cycle write mem[2]=0x6 with ra=1 -> rv=0x3 one cycle later.
REQ-026 we=0, wa=2, wv=0x9, ra=1 -> rv stays 0x3; mem[2] still 0x6 (no write when we=0).
REQ-027 we=1, wa=1, wv=0xC, ra=2 -> rv=0x6 next cycle; mem[1] becomes 0xC.
REQ-028 Collision: we=1, wa=1, wv=0xF, ra=1 -> rv=0xC next cycle (READ_FIRST); next cycle with we=0, ra=1 -> rv=0xF.
REQ-029 Assert rst_n low mid-sequence -> rv=0 immediately (no clock edge); release, read ra=1 -> rv=0xF (contents retained).
REQ-030 During reset, we=1, wa=3, wv=0x5 -> after release, read ra=3 -> rv=0x0 (write suppressed).
